instr_prefetch: RTL and testbench

Instruction prefetch buffer between program Memory and the CPU decode stage. Reads program bytes sequentially over the 8-bit memory address/data interface and queues them, with their addresses, in a small FIFO. Decode consumes one byte per valid/ready handshake. A redirect (jump/branch) flushes the queue and restarts fetching at a new address.

---
 rtl/instr_prefetch.sv | 86 ++++++++
 tb/tb_instr_prefetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: fetches program bytes sequentially from
// Memory and queues {address, byte} pairs for the decode stage. A redirect
// flushes the queue and restarts fetching at a new address.
module instr_prefetch #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rd,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] fetchPc;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;

    // Handshake and head-of-queue decode. A pop never frees space for a
    // push in the same cycle, so fetching stalls whenever the queue is full.
    always_comb begin
        fifoFull    = (count == CNT_W'(DEPTH));
        fifoEmpty   = (count == '0);
        mem_addr    = fetchPc;
        mem_rd      = rst & ~fifoFull & ~redirect;
        push        = mem_rd;
        instr_valid = ~fifoEmpty & ~redirect;
        pop         = instr_valid & instr_ready;
        instr_data  = fifoEmpty ? '0 : dataMem[rdPtr];
        instr_addr  = fifoEmpty ? '0 : addrMem[rdPtr];
    end

    // Fetch address, queue pointers and occupancy; redirect outranks push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc <= ADDR_W'(RESET_ADDR);
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (redirect) begin
            fetchPc <= redirect_addr;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                wrPtr   <= wrPtr + PTR_W'(1);
                fetchPc <= fetchPc + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are only observed while occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            dataMem[wrPtr] <= mem_data;
            addrMem[wrPtr] <= fetchPc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed testbench for instr_prefetch with a combinational memory model
// M[a] = a ^ 0x5A.
module tb_instr_prefetch;

    logic       clk;
    logic       rst;
    logic [7:0] memAddr;
    logic [7:0] memData;
    logic       memRd;
    logic       redirect;
    logic [7:0] redirectAddr;
    logic       instrValid;
    logic       instrReady;
    logic [7:0] instrData;
    logic [7:0] instrAddr;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    instr_prefetch #(
        .ADDR_W(8),
        .DATA_W(8),
        .DEPTH(4),
        .RESET_ADDR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(memAddr),
        .mem_data(memData),
        .mem_rd(memRd),
        .redirect(redirect),
        .redirect_addr(redirectAddr),
        .instr_valid(instrValid),
        .instr_ready(instrReady),
        .instr_data(instrData),
        .instr_addr(instrAddr),
        .count(count)
    );

    // Program memory model: combinational read of the fetch address.
    assign memData = memAddr ^ 8'h5A;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One comparison against a hand-computed expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the head entry for program address a.
    task automatic checkHead(input string tag, input logic [7:0] a);
        checkOutput({tag, "_valid"}, 32'(instrValid), 32'd1);
        checkOutput({tag, "_addr"}, 32'(instrAddr), 32'(a));
        checkOutput({tag, "_data"}, 32'(instrData), 32'(a ^ 8'h5A));
    endtask

    // Directed sequence covering streaming, backpressure, redirect, wrap and reset.
    initial begin
        rst          = 1'b0;
        redirect     = 1'b0;
        redirectAddr = 8'h00;
        instrReady   = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(instrValid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_memaddr", 32'(memAddr), 32'd0);
        checkOutput("rst_memrd", 32'(memRd), 32'd0);
        checkOutput("rst_idata", 32'(instrData), 32'd0);
        checkOutput("rst_iaddr", 32'(instrAddr), 32'd0);

        $display("[TB] streaming with ready held high");
        rst        = 1'b1;
        instrReady = 1'b1;
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkHead("stream", 8'(i));
            checkOutput("stream_count", 32'(count), 32'd1);
            applyStimulus();
        end

        $display("[TB] backpressure until full");
        rst        = 1'b0;
        instrReady = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_memrd", 32'(memRd), 32'd0);
        checkOutput("full_memaddr", 32'(memAddr), 32'h04);
        checkHead("full_head", 8'h00);
        applyStimulus();
        checkOutput("full_hold_count", 32'(count), 32'd4);
        checkOutput("full_hold_memaddr", 32'(memAddr), 32'h04);
        instrReady = 1'b1;
        #1;
        checkOutput("full_pop_memrd", 32'(memRd), 32'd0);
        applyStimulus();
        checkHead("drain1", 8'h01);
        checkOutput("drain1_count", 32'(count), 32'd3);
        checkOutput("drain1_memrd", 32'(memRd), 32'd1);
        checkOutput("drain1_memaddr", 32'(memAddr), 32'h04);
        applyStimulus();
        checkHead("drain2", 8'h02);
        checkOutput("drain2_count", 32'(count), 32'd3);
        applyStimulus();
        checkHead("drain3", 8'h03);
        checkOutput("drain3_count", 32'(count), 32'd3);

        $display("[TB] redirect with three entries queued");
        redirect     = 1'b1;
        redirectAddr = 8'h40;
        #1;
        checkOutput("redir_valid_now", 32'(instrValid), 32'd0);
        checkOutput("redir_memrd_now", 32'(memRd), 32'd0);
        applyStimulus();
        redirect = 1'b0;
        #1;
        checkOutput("redir_count", 32'(count), 32'd0);
        checkOutput("redir_valid", 32'(instrValid), 32'd0);
        checkOutput("redir_memaddr", 32'(memAddr), 32'h40);
        checkOutput("redir_memrd", 32'(memRd), 32'd1);
        applyStimulus();
        checkHead("redir_first", 8'h40);
        checkOutput("redir_first_count", 32'(count), 32'd1);

        $display("[TB] address wrap-around");
        redirect     = 1'b1;
        redirectAddr = 8'hFE;
        applyStimulus();
        redirect = 1'b0;
        applyStimulus();
        checkHead("wrap0", 8'hFE);
        applyStimulus();
        checkHead("wrap1", 8'hFF);
        applyStimulus();
        checkHead("wrap2", 8'h00);
        applyStimulus();
        checkHead("wrap3", 8'h01);

        $display("[TB] asynchronous reset mid-operation");
        instrReady = 1'b0;
        applyStimulus();
        checkOutput("pre_rst_count", 32'(count), 32'd2);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(instrValid), 32'd0);
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_memaddr", 32'(memAddr), 32'd0);
        checkOutput("arst_memrd", 32'(memRd), 32'd0);
        checkOutput("arst_idata", 32'(instrData), 32'd0);
        rst        = 1'b1;
        instrReady = 1'b1;
        applyStimulus();
        checkHead("restart0", 8'h00);
        applyStimulus();
        checkHead("restart1", 8'h01);

        $display("[TB] redirect coinciding with a ready head");
        redirect     = 1'b1;
        redirectAddr = 8'h80;
        #1;
        checkOutput("coinc_valid_now", 32'(instrValid), 32'd0);
        checkOutput("coinc_memrd_now", 32'(memRd), 32'd0);
        applyStimulus();
        redirect = 1'b0;
        #1;
        checkOutput("coinc_count", 32'(count), 32'd0);
        checkOutput("coinc_memaddr", 32'(memAddr), 32'h80);
        applyStimulus();
        checkHead("coinc_first", 8'h80);
        applyStimulus();
        checkHead("coinc_second", 8'h81);
        checkOutput("coinc_count2", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
